// File: rtl/imem_pkg.sv
// Shared constants and helpers for the RV32 instruction memory.
// Holds the bus-width defaults, the fault/reset NOP and byte-to-word conversion.
package imem_pkg;

    localparam int unsigned INSTR_WIDTH_DEFAULT   = 32;
    localparam int unsigned ADDRESS_WIDTH_DEFAULT = 32;

    // addi x0,x0,0: a harmless word to fetch when nothing valid is available.
    localparam logic [INSTR_WIDTH_DEFAULT-1:0] NOP_WORD_DEFAULT = 32'h00000013;

    function automatic logic [ADDRESS_WIDTH_DEFAULT-3:0] word_index(
        input logic [ADDRESS_WIDTH_DEFAULT-1:0] addr
    );
        return (ADDRESS_WIDTH_DEFAULT-2)'(addr >> 2);
    endfunction

endpackage

// File: rtl/imem_addr_check.sv
// Alignment and range qualification of a byte address against a word array.
// Shared by the fetch path and the load port.
module imem_addr_check #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned LENGTH        = 64
) (
    input  logic [ADDRESS_WIDTH-1:0] addr_i,
    output logic                     misaligned_o,
    output logic                     out_of_range_o
);

    localparam int unsigned IndexWidth = ADDRESS_WIDTH - 2;
    // One spare bit so LENGTH itself always fits; high address bits then never alias.
    localparam logic [IndexWidth:0] LengthExt = (IndexWidth + 1)'(LENGTH);

    always_comb begin
        misaligned_o   = addr_i[1:0] != 2'b00;
        out_of_range_o = {1'b0, addr_i[ADDRESS_WIDTH-1:2]} >= LengthExt;
    end

endmodule

// File: rtl/instruction_memory.sv
// Word-organised instruction store with a zero-latency combinational fetch,
// a synchronous load port, and alignment/range fault reporting.
module instruction_memory
    import imem_pkg::*;
#(
    parameter int unsigned              INSTR_WIDTH   = INSTR_WIDTH_DEFAULT,
    parameter int unsigned              ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
    parameter int unsigned              LENGTH        = 64,
    parameter string                    PROGRAM       = "factorial.txt",
    parameter logic [INSTR_WIDTH-1:0]   NOP_WORD      = INSTR_WIDTH'(NOP_WORD_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] Adress,
    output logic [INSTR_WIDTH-1:0]   instruction,
    input  logic                     load_en,
    input  logic [ADDRESS_WIDTH-1:0] load_addr,
    input  logic [INSTR_WIDTH-1:0]   load_data,
    output logic                     misaligned,
    output logic                     out_of_range,
    output logic                     fault_sticky
);

    localparam int unsigned IdxWidth = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    logic [INSTR_WIDTH-1:0] memory [0:LENGTH-1];

    logic fetch_misaligned, fetch_out_of_range;
    logic load_misaligned, load_out_of_range;
    logic fault_sticky_q, fault_sticky_d;

    imem_addr_check #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .LENGTH        (LENGTH)
    ) u_fetch_check (
        .addr_i         (Adress),
        .misaligned_o   (fetch_misaligned),
        .out_of_range_o (fetch_out_of_range)
    );

    imem_addr_check #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .LENGTH        (LENGTH)
    ) u_load_check (
        .addr_i         (load_addr),
        .misaligned_o   (load_misaligned),
        .out_of_range_o (load_out_of_range)
    );

    always_comb begin
        instruction = NOP_WORD;
        if (rst_n && !fetch_misaligned && !fetch_out_of_range) begin
            instruction = memory[IdxWidth'(word_index(ADDRESS_WIDTH_DEFAULT'(Adress)))];
        end
    end

    // Contents survive reset, so the load port is deliberately not gated by rst_n.
    always_ff @(posedge clk) begin
        if (load_en && !load_misaligned && !load_out_of_range) begin
            memory[IdxWidth'(word_index(ADDRESS_WIDTH_DEFAULT'(load_addr)))] <= load_data;
        end
    end

    always_comb begin
        fault_sticky_d = fault_sticky_q | fetch_misaligned | fetch_out_of_range;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_sticky_q <= 1'b0;
        end else begin
            fault_sticky_q <= fault_sticky_d;
        end
    end

    assign misaligned   = fetch_misaligned;
    assign out_of_range = fetch_out_of_range;
    assign fault_sticky = fault_sticky_q;

endmodule

// File: tb/tb_instruction_memory.sv
// Scoreboard bench for instruction_memory: stimulus pushes predicted outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_instruction_memory;

    localparam int          LEN = 64;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adress = 32'h0;
    logic [31:0] instruction;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = 32'h0;
    logic [31:0] load_data = 32'h0;
    logic        misaligned, out_of_range, fault_sticky;

    typedef struct {
        logic [31:0] instr;
        logic        mis;
        logic        oor;
        logic        sticky;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [LEN];
    bit          model_sticky = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    instruction_memory #(
        .LENGTH  (LEN),
        .PROGRAM ("")
    ) DUT (
        .clk          (clk),
        .rst_n        (rst_n),
        .Adress       (adress),
        .instruction  (instruction),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .misaligned   (misaligned),
        .out_of_range (out_of_range),
        .fault_sticky (fault_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, got, want);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, ".instruction"}, instruction, e.instr);
            check({e.name, ".misaligned"}, {31'b0, misaligned}, {31'b0, e.mis});
            check({e.name, ".out_of_range"}, {31'b0, out_of_range}, {31'b0, e.oor});
            check({e.name, ".fault_sticky"}, {31'b0, fault_sticky}, {31'b0, e.sticky});
        end
    end

    // One cycle: drive just after posedge, predict what the DUT shows before the
    // next posedge, then fold that edge's effects into the model.
    task automatic step(input logic [31:0] a, input bit le, input logic [31:0] la,
                        input logic [31:0] ld, input bit rn, input string nm);
        exp_t e;
        bit   mis;
        bit   oor;
        @(posedge clk);
        #1;
        adress    = a;
        load_en   = le;
        load_addr = la;
        load_data = ld;
        rst_n     = rn;
        mis = (a % 4) != 0;
        oor = (longint'(a) / 4) >= LEN;
        e.mis    = mis;
        e.oor    = oor;
        e.instr  = (!rn || mis || oor) ? NOP : model_mem[a / 4];
        e.sticky = rn ? model_sticky : 1'b0;
        e.name   = nm;
        exp_q.push_back(e);
        if (!rn) model_sticky = 1'b0;
        else if (mis || oor) model_sticky = 1'b1;
        if (le && (la % 4) == 0 && (longint'(la) / 4) < LEN) model_mem[la / 4] = ld;
    endtask

    initial begin : stimulus
        logic [31:0] a, la, ld;
        bit          le, rn;
        int unsigned kind;
        logic [31:0] w;

        // Program the array through the load port while held in reset.
        for (int i = 0; i < LEN; i++) begin
            w = $urandom;
            if (i == 0) w = 32'h00500093;
            if (i == 1) w = 32'h00100113;
            if (i == 2) w = 32'h022081b3;
            step(32'h4, 1'b1, i * 4, w, 1'b0, "preload");
        end

        step(32'h0, 1'b0, 0, 0, 1'b1, "fetch0");
        step(32'h4, 1'b0, 0, 0, 1'b1, "fetch4");
        step(32'h8, 1'b0, 0, 0, 1'b1, "fetch8");
        step(32'h102, 1'b0, 0, 0, 1'b1, "misalign");
        step(32'h0, 1'b0, 0, 0, 1'b1, "sticky_set");
        step(32'h0, 1'b0, 0, 0, 1'b0, "sticky_rst");
        step(32'h0, 1'b0, 0, 0, 1'b1, "sticky_clear");
        step(32'h100, 1'b0, 0, 0, 1'b1, "oor_0x100");
        step(32'hFC, 1'b0, 0, 0, 1'b1, "word63");
        step(32'h8, 1'b1, 32'h8, 32'hDEADBEEF, 1'b1, "rdw_old");
        step(32'h8, 1'b0, 0, 0, 1'b1, "rdw_new");
        step(32'h8, 1'b1, 32'h9, 32'h11111111, 1'b1, "load_misaligned");
        step(32'h8, 1'b1, 32'h100, 32'h22222222, 1'b1, "load_oor");
        step(32'h8, 1'b0, 0, 0, 1'b1, "load_dropped");
        step(32'h0, 1'b0, 0, 0, 1'b1, "no_alias_load");
        step(32'h4, 1'b0, 0, 0, 1'b0, "async_reset");
        step(32'h4, 1'b0, 0, 0, 1'b1, "reset_release");
        step(32'h80000000, 1'b0, 0, 0, 1'b1, "high_addr");

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 7)       a = $urandom_range(0, LEN - 1) * 4;
            else if (kind == 7) a = ($urandom_range(0, LEN - 1) * 4) | $urandom_range(1, 3);
            else if (kind == 8) a = $urandom_range(LEN, 1000) * 4;
            else                a = $urandom;
            le = $urandom_range(0, 2) == 0;
            kind = $urandom_range(0, 9);
            if (kind < 8)       la = $urandom_range(0, LEN - 1) * 4;
            else if (kind == 8) la = $urandom_range(0, LEN * 4 - 1);
            else                la = $urandom;
            ld = $urandom;
            rn = $urandom_range(0, 29) != 0;
            step(a, le, la, ld, rn, "random");
        end

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
